// File: rtl/welcome_pkg.sv
// Shared constants and state encodings for the welcome-detector blocks:
// ASCII characters of "Hello", arbiter states and matcher states.
package welcome_pkg;

    localparam logic [7:0] CH_H = 8'h48;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_L = 8'h6C;
    localparam logic [7:0] CH_O = 8'h6F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4
    } match_state_e;

    // Where the matcher lands after a mismatch: an 'H' may start a new match.
    function automatic match_state_e restart_state(input logic [7:0] b);
        return (b == CH_H) ? M1 : M0;
    endfunction

endpackage

// File: rtl/hello_matcher.sv
// Case-sensitive "Hello" detector over a byte stream; hit is a registered
// one-cycle pulse, hit_next is the same pulse one cycle early.
module hello_matcher
    import welcome_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       byte_vld,
    input  logic [7:0] byte_data,
    output logic       hit,
    output logic       hit_next
);

    match_state_e state_q, state_d;
    logic         hit_q;

    always_comb begin
        state_d  = state_q;
        hit_next = 1'b0;
        if (clr) begin
            state_d = M0;
        end else if (byte_vld) begin
            unique case (state_q)
                M0:      state_d = restart_state(byte_data);
                M1:      state_d = (byte_data == CH_E) ? M2 : restart_state(byte_data);
                M2:      state_d = (byte_data == CH_L) ? M3 : restart_state(byte_data);
                M3:      state_d = (byte_data == CH_L) ? M4 : restart_state(byte_data);
                M4: begin
                    if (byte_data == CH_O) begin
                        state_d  = M0;
                        hit_next = 1'b1;
                    end else begin
                        state_d = restart_state(byte_data);
                    end
                end
                default: state_d = M0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_next;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/hello_match_arb.sv
// Round-robin frame arbiter sharing one "Hello" matcher between two requesters.
// Optional idle-grant revocation is enabled by defining ARB_TIMEOUT_EN.
module hello_match_arb
    import welcome_pkg::*;
#(
    parameter int unsigned MATCH_W = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         valid,
    input  logic [7:0]         data0,
    input  logic [7:0]         data1,
    input  logic [1:0]         last,
    output logic [1:0]         ready,
    output logic [1:0]         grant,
    output logic [1:0]         match,
    output logic [MATCH_W-1:0] cnt0,
    output logic [MATCH_W-1:0] cnt1,
    output logic               timeout
);

    if (MATCH_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("hello_match_arb: MATCH_W and TIMEOUT must be at least 1");
    end

    arb_state_e         state_q, state_d;
    logic               rr_q, rr_d;
    logic [1:0]         owner_q, owner_d;
    logic [MATCH_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]         gnt_w;
    logic               accept, acc_last, start, revoke;
    logic [7:0]         acc_data;
    logic               hit, hit_next;

    assign gnt_w    = {state_q == GNT1, state_q == GNT0};
    assign ready    = gnt_w;
    assign grant    = gnt_w;
    assign accept   = |(valid & gnt_w);
    assign acc_data = (state_q == GNT1) ? data1 : data0;
    assign acc_last = (state_q == GNT1) ? last[1] : last[0];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                start = (valid != 2'b00);
                if (valid == 2'b01)      state_d = GNT0;
                else if (valid == 2'b10) state_d = GNT1;
                else if (valid == 2'b11) state_d = rr_q ? GNT1 : GNT0;
            end
            GNT0, GNT1: begin
                if ((accept && acc_last) || revoke) begin
                    state_d = IDLE;
                    rr_d    = (state_q == GNT0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // hit_next is only raised for an accepted byte, so gnt_w names its owner.
    always_comb begin
        owner_d = accept ? gnt_w : owner_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (hit_next && gnt_w[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + MATCH_W'(1);
        if (hit_next && gnt_w[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + MATCH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q;
    logic              own_valid;

    // Revoke on the cycle that would bring the idle count up to TIMEOUT.
    assign own_valid = |(valid & gnt_w);
    assign revoke    = (state_q != IDLE) && !own_valid && (idle_q == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        idle_d = '0;
        if ((state_q != IDLE) && !own_valid && !revoke) idle_d = idle_q + IDLE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= revoke;
        end
    end

    assign timeout = timeout_q;
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    hello_matcher u_matcher (
        .clk       (clk),
        .rst       (rst),
        .clr       (start | revoke),
        .byte_vld  (accept),
        .byte_data (acc_data),
        .hit       (hit),
        .hit_next  (hit_next)
    );

    assign match = owner_q & {2{hit}};
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_hello_match_arb.sv
// Scoreboard bench for hello_match_arb: drivers push expected match pulses,
// a negedge monitor pops and compares them.
module tb_hello_match_arb;

    localparam int unsigned MATCH_W = 8;
    localparam int          CNT_MAX = (1 << MATCH_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid0, valid1, last0, last1;
    logic [7:0] data0, data1;
    logic [1:0] ready, grant, match;
    logic [MATCH_W-1:0] cnt0, cnt1;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses0 = 0;
    int pulses1 = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    typedef struct {
        logic [1:0] mask;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hello_match_arb #(.MATCH_W(MATCH_W), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   ({valid1, valid0}),
        .data0   (data0),
        .data1   (data1),
        .last    ({last1, last0}),
        .ready   (ready),
        .grant   (grant),
        .match   (match),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .timeout (timeout)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Match monitor: every pulse must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (match !== 2'b00) begin
            checks++;
            if (match === 2'b01) pulses0++;
            if (match === 2'b10) pulses1++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL match_unexpected: got %b at cycle %0d, expected no pulse", match, cyc);
            end else begin
                e = sb.pop_front();
                if (match !== e.mask || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL match_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                             match, cyc, e.mask, e.cyc);
                end
            end
        end
    end

    function automatic int model_step(input int st, input logic [7:0] b, output bit hit);
        string pat = "Hello";
        logic [7:0] c;
        hit = 1'b0;
        c = pat[st];
        if (b == c) begin
            if (st == 4) begin
                hit = 1'b1;
                return 0;
            end
            return st + 1;
        end
        c = pat[0];
        return (b == c) ? 1 : 0;
    endfunction

    task automatic send(input int r, input string s, input bit last_at_end);
        int st = 0;
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] b;
            bit acc;
            bit hit;
            exp_t e;
            b = s[i];
            if (r == 0) begin
                valid0 = 1'b1; data0 = b; last0 = last_at_end && (i == s.len() - 1);
            end else begin
                valid1 = 1'b1; data1 = b; last1 = last_at_end && (i == s.len() - 1);
            end
            acc = 1'b0;
            for (int w = 0; w < 300 && !acc; w++) begin
                @(negedge clk);
                acc = (r == 0) ? ready[0] : ready[1];
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_wait: requester %0d byte %0d not accepted, ready=%b expected accept", r, i, ready);
            end else begin
                st = model_step(st, b, hit);
                if (hit) begin
                    e.mask = (r == 0) ? 2'b01 : 2'b10;
                    e.cyc  = cyc;
                    sb.push_back(e);
                    if (r == 0 && exp_cnt0 < CNT_MAX) exp_cnt0++;
                    if (r == 1 && exp_cnt1 < CNT_MAX) exp_cnt1++;
                end
            end
        end
        if (r == 0) begin valid0 = 1'b0; last0 = 1'b0; end
        else        begin valid1 = 1'b0; last1 = 1'b0; end
    endtask

    task automatic drain_and_check(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d outstanding expected pulses, expected 0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (cnt0 !== MATCH_W'(exp_cnt0)) begin
            errors++;
            $display("FAIL %s_cnt0: got %0d expected %0d", name, cnt0, exp_cnt0);
        end
        checks++;
        if (cnt1 !== MATCH_W'(exp_cnt1)) begin
            errors++;
            $display("FAIL %s_cnt1: got %0d expected %0d", name, cnt1, exp_cnt1);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({ready, grant, match, timeout} !== 7'b0 || cnt0 !== '0 || cnt1 !== '0) begin
            errors++;
            $display("FAIL %s: got ready=%b grant=%b match=%b timeout=%b cnt0=%0d cnt1=%0d expected all zero",
                     name, ready, grant, match, timeout, cnt0, cnt1);
        end
    endtask

    task automatic test_reset();
        valid0 = 1'b0; valid1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data0 = '0; data1 = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("idle_no_valid");
    endtask

    task automatic test_back_to_back();
        logic [1:0] tr[24];
        fork
            begin send(0, "Hello", 1'b1); send(0, "Hello", 1'b1); end
            begin send(1, "Hello", 1'b1); send(1, "Hello", 1'b1); end
            begin
                for (int k = 0; k < 24; k++) begin
                    @(negedge clk);
                    tr[k] = grant;
                end
            end
        join
        for (int k = 0; k < 24; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 6 == 0) ? 2'b00 : (((k / 6) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (tr[k] !== exp_g) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b expected %b", k, tr[k], exp_g);
            end
        end
        drain_and_check("b2b");
    endtask

    task automatic test_single_frame();
        int p0, p1;
        p0 = pulses0;
        p1 = pulses1;
        send(0, "IAHoHeLHelloMO", 1'b1);
        drain_and_check("single");
        checks++;
        if (pulses0 - p0 != 1 || pulses1 - p1 != 0) begin
            errors++;
            $display("FAIL single_pulses: got %0d/%0d expected 1/0", pulses0 - p0, pulses1 - p1);
        end
    endtask

    task automatic test_cross_frame();
        int p0, p1;
        p0 = pulses0;
        p1 = pulses1;
        send(0, "Hel", 1'b1);
        send(1, "lo", 1'b1);
        send(0, "Hell", 1'b1);
        send(0, "o", 1'b1);
        drain_and_check("cross");
        checks++;
        if (pulses0 != p0 || pulses1 != p1) begin
            errors++;
            $display("FAIL cross_pulses: got %0d/%0d new pulses expected 0/0", pulses0 - p0, pulses1 - p1);
        end
    endtask

    task automatic test_saturation();
        int p0;
        p0 = pulses0;
        for (int n = 0; n < 300; n++) send(0, "Hello", 1'b1);
        drain_and_check("sat");
        checks++;
        if (cnt0 !== MATCH_W'(CNT_MAX)) begin
            errors++;
            $display("FAIL sat_value: got %0d expected %0d", cnt0, CNT_MAX);
        end
        checks++;
        if (pulses0 - p0 != 300) begin
            errors++;
            $display("FAIL sat_pulses: got %0d expected 300", pulses0 - p0);
        end
    endtask

    task automatic test_reset_mid_frame();
        send(0, "Hell", 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        sb.delete();
        check_reset_outputs("rst_mid_frame");
        send(0, "o", 1'b1);
        drain_and_check("after_rst");
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        seen = 1'b0;
        fork
            send(0, "He", 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                send(1, "llo", 1'b1);
            end
            begin
                for (int k = 0; k < 80 && !seen; k++) begin
                    @(negedge clk);
                    if (timeout === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    checks++;
                    if (grant !== 2'b00) begin
                        errors++;
                        $display("FAIL timeout_release: got grant %b expected 00", grant);
                    end
                    @(negedge clk);
                    checks++;
                    if (grant !== 2'b10) begin
                        errors++;
                        $display("FAIL timeout_next_grant: got grant %b expected 10", grant);
                    end
                end
            end
        join
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_pulse: got no pulse expected one");
        end
        send(0, "llo", 1'b1);
        drain_and_check("timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_single_frame();
        test_cross_frame();
        test_saturation();
        test_reset_mid_frame();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hello_match_arb.md
# hello_match_arb

Round-robin frame arbiter that shares a single "Hello" string matcher between two byte-stream requesters. Each requester offers frames of ASCII bytes over a valid/ready handshake. The block grants one requester at a time for a whole frame and feeds the granted bytes into the matcher. It reports per-requester match pulses and saturating match counts, and sits between the UART/byte sources and the LED/status logic of the welcome-detector design.

## Interface
- `MATCH_W`, 8 — width of each per-requester match counter.
- `TIMEOUT`, 16 — idle-cycle limit inside a granted frame; used only when `ARB_TIMEOUT_EN` is defined.
- `clk` input 1 — system clock; all logic is on the rising edge.
- `rst` input 1 — reset; synchronous, active-high.
- `valid` input 2 — per-requester byte valid; bit i belongs to requester i.
- `data0` input 8 — requester 0 ASCII byte.
- `data1` input 8 — requester 1 ASCII byte.
- `last` input 2 — per-requester end-of-frame marker; qualified by valid & ready.
- `ready` output 2 — per-requester accept; combinational from the grant state.
- `grant` output 2 — one-hot current owner; 0 when idle.
- `match` output 2 — one-cycle pulse to the requester whose frame completed "Hello".
- `cnt0` output MATCH_W — requester 0 saturating match count.
- `cnt1` output MATCH_W — requester 1 saturating match count.
- `timeout` output 1 — one-cycle pulse when a frame is revoked; tied to 0 when `ARB_TIMEOUT_EN` is not defined.

## Operation
- Arbiter FSM states: IDLE, GNT0, GNT1. The round-robin pointer `rr` names the requester preferred next.
- IDLE: if exactly one `valid` bit is set, go to that requester's GNT state. If both are set, go to GNT(rr). If neither is set, stay in IDLE.
- GNTi: `ready[i]`=1 and the other ready bit is 0. A byte is accepted when `valid[i]&ready[i]`. Accepting a byte with `last[i]`=1 moves the FSM to IDLE and sets `rr` to the other requester.
- A one-byte frame (`last` on the first byte) is legal.
- Matcher states: M0 (none), M1 ("H"), M2 ("He"), M3 ("Hel"), M4 ("Hell"). Matching is case-sensitive.
  - Each accepted byte advances the state on the expected character.
  - On a mismatch the next state is M1 if the byte is "H", else M0.
  - Accepting "o" in M4 produces a match and returns the matcher to M0.
- The matcher is forced to M0 on every IDLE→GNT transition. Matches never span frames or requesters.
- On a match, `match[owner]` pulses and `cnt[owner]` increments, saturating at 2^MATCH_W−1.
- Requester i must hold `valid[i]` and its data/last stable until accepted. The block never drops an accepted byte.

## Timing
- Reset values: FSM=IDLE, `rr`=0, matcher=M0, `ready`=0, `grant`=0, `match`=0, `cnt0`=`cnt1`=0, `timeout`=0, idle counter=0.
- Grant latency: `valid` sampled high in IDLE gives `grant`/`ready` high in the next cycle.
- Each frame costs one IDLE bubble cycle. Back-to-back frames from alternating requesters therefore have one dead cycle between them.
- Match latency: `match` and the counter update are registered, appearing the cycle after the "o" byte is accepted.
- Throughput inside a frame: one byte per cycle.
- A `last` byte that completes "Hello" still produces the match pulse, in the same cycle the FSM is in IDLE.
- `rst` asserted mid-frame: all state returns to reset values at the next edge. A partial match is discarded and the counters clear.
- Both requesters valid continuously: grants alternate 0,1,0,1 per frame. Neither requester starves.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In GNTi, an idle counter increments each cycle `valid[i]`=0 and clears on any accepted byte.
  - When the counter reaches `TIMEOUT`, the grant is revoked. The FSM goes to IDLE, `rr` moves to the other requester, the matcher goes to M0, and `timeout` pulses for one cycle.
- `ARB_TIMEOUT_EN` undefined: there is no idle counter, `timeout` is constant 0, and a grant is held until `last` is accepted.

## Structure
- Shared package `welcome_pkg`:
  - the ASCII constants "H", "e", "l", "o";
  - the arbiter state enum (IDLE/GNT0/GNT1);
  - the matcher state enum (M0–M4).
- Sub-module `hello_matcher`:
  - inputs `clk`, `rst`, `clr`, `byte_vld`, `byte[7:0]`; output `hit` (registered pulse);
  - the top level instantiates it once and muxes the granted data into it.
- The arbiter FSM, round-robin pointer, counters and timeout logic stay in the top level.

## Test plan
- Requester 0 only, frame "IAHoHeLHelloMO" with `last` on "O" → exactly one `match[0]` pulse, one cycle after "o" of "Hello" is accepted; `cnt0`=1, `cnt1`=0.
- Both requesters valid from reset with frames "Hello" (`last` on "o") → grants alternate 0,1,0,1 with one IDLE cycle between frames; `cnt0`=`cnt1`=2 after four frames.
- Requester 0 sends "Hel" with `last`, then requester 1 sends "lo" → no match on either requester (the matcher clears at the frame boundary).
- Requester 0 sends 300 "Hello" frames with MATCH_W=8 → `cnt0` saturates at 255 and `match[0]` still pulses 300 times.
- `rst` pulsed for one cycle after "Hell" has been accepted, then "o" is sent in a new frame → no match; all outputs equal their reset values in the cycle after `rst`.
- With `ARB_TIMEOUT_EN`, TIMEOUT=16: requester 0 sends "He" then drops `valid` for 16 cycles → `timeout` pulses, the grant is released, a waiting requester 1 is granted next, and requester 0's partial "He" does not combine with later bytes.
